uart_tx_fifo: RTL

//  Buffered, configurable UART transmitter; next generation of the 8N1 display-link TX.

---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: ready/valid input FIFO feeding a frame serialiser with
// runtime-selectable parity and stop-bit count; the bit timer restarts at every frame.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIVISOR    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    output logic                          txo,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIVISOR);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(0);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic                 in_ready_q;

    state_e               state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 par_en_q;
    logic                 two_stop_q;
    logic                 stop2_q;
    logic                 txo_q;
    logic                 busy_q;

    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_empty_s;
    logic                 bit_end_s;
    logic                 frame_end_s;
    logic                 next_idle_s;
    logic [DATA_BITS-1:0] head_s;

    function automatic logic parity_f(input logic [DATA_BITS-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    // Handshake, frame-boundary decode and next FIFO level.
    always_comb begin
        fifo_empty_s = (level_q == LVL_ZERO);
        push_s       = in_valid & in_ready_q;
        bit_end_s    = (state_q != IDLE) && (baud_q == BAUD_LAST);
        frame_end_s  = (state_q == STOP) && bit_end_s && (!two_stop_q || stop2_q);
        pop_s        = ((state_q == IDLE) || frame_end_s) && !fifo_empty_s;
        next_idle_s  = ((state_q == IDLE) || frame_end_s) && fifo_empty_s;
        head_s       = mem_q[rd_ptr_q];
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            level_q    <= LVL_ZERO;
            in_ready_q <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q    <= level_d;
            in_ready_q <= (level_d != LVL_FULL);
        end
    end

    // Frame serialiser; a pop always starts a new frame, including straight out of STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= BAUD_ZERO;
            bit_idx_q  <= BIT_ZERO;
            shift_q    <= {DATA_BITS{1'b0}};
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            stop2_q    <= 1'b0;
            txo_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= !next_idle_s || (level_d != LVL_ZERO);
            if (pop_s) begin
                shift_q    <= head_s;
                par_q      <= parity_f(head_s, parity_odd);
                par_en_q   <= parity_en;
                two_stop_q <= two_stop;
                stop2_q    <= 1'b0;
                bit_idx_q  <= BIT_ZERO;
                baud_q     <= BAUD_ZERO;
                txo_q      <= 1'b0;
                state_q    <= START;
            end else if (state_q == IDLE) begin
                baud_q <= BAUD_ZERO;
                txo_q  <= 1'b1;
            end else begin
                baud_q <= bit_end_s ? BAUD_ZERO : baud_q + BAUD_ONE;
                if (bit_end_s) begin
                    case (state_q)
                        START: begin
                            txo_q     <= shift_q[0];
                            bit_idx_q <= BIT_ZERO;
                            state_q   <= DATA;
                        end
                        DATA: begin
                            if (bit_idx_q == BIT_LAST) begin
                                stop2_q <= 1'b0;
                                if (par_en_q) begin
                                    txo_q   <= par_q;
                                    state_q <= PARITY;
                                end else begin
                                    txo_q   <= 1'b1;
                                    state_q <= STOP;
                                end
                            end else begin
                                txo_q     <= shift_q[1];
                                shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                                bit_idx_q <= bit_idx_q + BIT_ONE;
                            end
                        end
                        PARITY: begin
                            txo_q   <= 1'b1;
                            stop2_q <= 1'b0;
                            state_q <= STOP;
                        end
                        STOP: begin
                            txo_q <= 1'b1;
                            if (frame_end_s) begin
                                state_q <= IDLE;
                            end else begin
                                stop2_q <= 1'b1;
                            end
                        end
                        default: begin
                            txo_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign txo        = txo_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;

endmodule
